// File: rtl/decode_pipe_if.sv
// Fetch/EX control bundle for decode_pipe: fetch-side inputs and registered EX controls.
// The master modport drives the fetch side; the slave modport is decode_pipe.
interface decode_pipe_if #(
   parameter int CNT_W = 32
);
   logic [31:0]      instr_F;
   logic             valid_F;
   logic             br_taken_EX;
   logic             illegal_clr;
   logic             alusrc_EX;
   logic             regwrite_EX;
   logic [2:0]       regsel_EX;
   logic [3:0]       aluop_EX;
   logic             gpio_we_EX;
   logic [1:0]       pcsrc_EX;
   logic             stall_FETCH;
   logic             illegal_sticky;
   logic [CNT_W-1:0] retired_cnt;

   modport master (
      output instr_F, valid_F, br_taken_EX, illegal_clr,
      input  alusrc_EX, regwrite_EX, regsel_EX, aluop_EX, gpio_we_EX,
             pcsrc_EX, stall_FETCH, illegal_sticky, retired_cnt
   );

   modport slave (
      input  instr_F, valid_F, br_taken_EX, illegal_clr,
      output alusrc_EX, regwrite_EX, regsel_EX, aluop_EX, gpio_we_EX,
             pcsrc_EX, stall_FETCH, illegal_sticky, retired_cnt
   );
endinterface

// File: rtl/decode_pipe.sv
// RV32 subset decoder with a FETCH->EX control register stage, redirect flush FSM,
// sticky illegal-instruction flag and retired-instruction counter.
module decode_pipe #(
   parameter int FLUSH_CYCLES = 1,
   parameter int EN_MUL       = 1,
   parameter int CNT_W        = 32
) (
   input logic          clk,
   input logic          rst_n,
   decode_pipe_if.slave bus
);
   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_cnt, w_cnt_nxt;

   logic [6:0]       w_opcode;
   logic [6:0]       w_funct7;
   logic [2:0]       w_funct3;
   logic             w_alusrc, w_regwrite, w_gpio_we, w_jump, w_branch, w_illegal;
   logic [2:0]       w_regsel;
   logic [3:0]       w_aluop;

   logic             r_alusrc, r_regwrite, r_gpio_we, r_jump, r_branch, r_valid;
   logic [2:0]       r_regsel;
   logic [3:0]       r_aluop;
   logic             r_illegal_sticky;
   logic [CNT_W-1:0] r_retired_cnt;

   logic             w_redirect, w_load, w_stall;
   logic [1:0]       w_pcsrc;
   logic             w_unused;

   assign w_opcode = bus.instr_F[6:0];
   assign w_funct3 = bus.instr_F[14:12];
   assign w_funct7 = bus.instr_F[31:25];
   assign w_unused = ^{bus.instr_F[24:15], bus.instr_F[11:7]};

   always_comb begin
      w_alusrc   = 1'b0;
      w_regwrite = 1'b0;
      w_regsel   = 3'd0;
      w_aluop    = 4'd0;
      w_gpio_we  = 1'b0;
      w_jump     = 1'b0;
      w_branch   = 1'b0;
      w_illegal  = 1'b0;
      case (w_opcode)
         7'b0110011: begin
            w_regwrite = 1'b1;
            w_regsel   = 3'd2;
            if (w_funct7 == 7'b0000000) begin
               case (w_funct3)
                  3'b000:  w_aluop = 4'b0011;
                  3'b111:  w_aluop = 4'b0000;
                  3'b110:  w_aluop = 4'b0001;
                  3'b100:  w_aluop = 4'b0010;
                  3'b001:  w_aluop = 4'b1000;
                  3'b101:  w_aluop = 4'b1001;
                  3'b010:  w_aluop = 4'b1100;
                  default: w_aluop = 4'b1101;
               endcase
            end else if (w_funct7 == 7'b0100000) begin
               case (w_funct3)
                  3'b000:  w_aluop   = 4'b0100;
                  3'b101:  w_aluop   = 4'b1010;
                  default: w_illegal = 1'b1;
               endcase
            end else if (w_funct7 == 7'b0000001 && EN_MUL != 0) begin
               case (w_funct3)
                  3'b000:  w_aluop   = 4'b0101;
                  3'b001:  w_aluop   = 4'b0110;
                  3'b011:  w_aluop   = 4'b0111;
                  default: w_illegal = 1'b1;
               endcase
            end else begin
               w_illegal = 1'b1;
            end
         end
         7'b0010011: begin
            w_regwrite = 1'b1;
            w_alusrc   = 1'b1;
            w_regsel   = 3'd2;
            case (w_funct3)
               3'b000:  w_aluop   = 4'b0011;
               3'b111:  w_aluop   = 4'b0000;
               3'b110:  w_aluop   = 4'b0001;
               3'b100:  w_aluop   = 4'b0010;
               3'b001:  w_aluop   = 4'b1000;
               3'b101:  w_aluop   = bus.instr_F[30] ? 4'b1010 : 4'b1001;
               default: w_illegal = 1'b1;
            endcase
         end
         7'b0110111: begin
            w_regwrite = 1'b1;
            w_regsel   = 3'd1;
         end
         7'b1101111: begin
            w_regwrite = 1'b1;
            w_regsel   = 3'd3;
            w_jump     = 1'b1;
         end
         7'b1110011: begin
            if (w_funct3 == 3'b001) begin
               w_gpio_we  = 1'b1;
               w_regwrite = 1'b1;
            end else begin
               w_illegal = 1'b1;
            end
         end
         7'b1100011: begin
            w_branch = 1'b1;
            case (w_funct3)
               3'b000, 3'b001: w_aluop   = 4'b0100;
               3'b100, 3'b101: w_aluop   = 4'b1100;
               3'b110, 3'b111: w_aluop   = 4'b1101;
               default:        w_illegal = 1'b1;
            endcase
         end
         default: w_illegal = 1'b1;
      endcase
      // an undecodable encoding must not leak partial controls into EX
      if (w_illegal) begin
         w_alusrc   = 1'b0;
         w_regwrite = 1'b0;
         w_regsel   = 3'd0;
         w_aluop    = 4'd0;
         w_gpio_we  = 1'b0;
         w_jump     = 1'b0;
         w_branch   = 1'b0;
      end
   end

   assign w_redirect = r_jump | (r_branch & bus.br_taken_EX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
         r_cnt   <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_RUN: begin
            if (w_redirect && FLUSH_CYCLES > 1) begin
               w_state_nxt = ST_FLUSH;
               w_cnt_nxt   = 2'(FLUSH_CYCLES - 1);
            end
         end
         ST_FLUSH: begin
            w_cnt_nxt = r_cnt - 2'd1;
            if (r_cnt == 2'd1) w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      w_stall = w_redirect | (r_state == ST_FLUSH);
      w_load  = (r_state == ST_RUN) & bus.valid_F & ~w_redirect;
      w_pcsrc = 2'd0;
      if (r_jump)                            w_pcsrc = 2'd1;
      else if (r_branch && bus.br_taken_EX)  w_pcsrc = 2'd2;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || !w_load) begin
         r_alusrc   <= 1'b0;
         r_regwrite <= 1'b0;
         r_regsel   <= 3'd0;
         r_aluop    <= 4'd0;
         r_gpio_we  <= 1'b0;
         r_jump     <= 1'b0;
         r_branch   <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_alusrc   <= w_alusrc;
         r_regwrite <= w_regwrite;
         r_regsel   <= w_regsel;
         r_aluop    <= w_aluop;
         r_gpio_we  <= w_gpio_we;
         r_jump     <= w_jump;
         r_branch   <= w_branch;
         r_valid    <= 1'b1;
      end
   end

   // set has priority over clear; squashed instructions never reach w_load
   always_ff @(posedge clk) begin
      if (!rst_n) r_illegal_sticky <= 1'b0;
      else        r_illegal_sticky <= (w_load & w_illegal) | (r_illegal_sticky & ~bus.illegal_clr);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_retired_cnt <= '0;
      else        r_retired_cnt <= r_retired_cnt + CNT_W'(r_valid);
   end

   assign bus.alusrc_EX      = r_alusrc;
   assign bus.regwrite_EX    = r_regwrite;
   assign bus.regsel_EX      = r_regsel;
   assign bus.aluop_EX       = r_aluop;
   assign bus.gpio_we_EX     = r_gpio_we;
   assign bus.pcsrc_EX       = w_pcsrc;
   assign bus.stall_FETCH    = w_stall;
   assign bus.illegal_sticky = r_illegal_sticky;
   assign bus.retired_cnt    = r_retired_cnt;
endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: decode table plus redirect, illegal, wrap and reset sequences.
// Three instances share stimulus: FLUSH_CYCLES=2, FLUSH_CYCLES=3, and FLUSH_CYCLES=1 with a 2-bit counter.
module tb_decode_pipe;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        valid, br, clr;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   decode_pipe_if #(.CNT_W(32)) if2 ();
   decode_pipe_if #(.CNT_W(32)) if3 ();
   decode_pipe_if #(.CNT_W(2))  ifw ();

   assign if2.instr_F = instr;  assign if2.valid_F = valid;
   assign if2.br_taken_EX = br; assign if2.illegal_clr = clr;
   assign if3.instr_F = instr;  assign if3.valid_F = valid;
   assign if3.br_taken_EX = br; assign if3.illegal_clr = clr;
   assign ifw.instr_F = instr;  assign ifw.valid_F = valid;
   assign ifw.br_taken_EX = br; assign ifw.illegal_clr = clr;

   decode_pipe #(.FLUSH_CYCLES(2), .EN_MUL(1), .CNT_W(32)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
   decode_pipe #(.FLUSH_CYCLES(3), .EN_MUL(1), .CNT_W(32)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
   decode_pipe #(.FLUSH_CYCLES(1), .EN_MUL(1), .CNT_W(2))  u_dutw (.clk(clk), .rst_n(rst_n), .bus(ifw.slave));

   logic [9:0] ctl2, ctl3, ctlw;
   assign ctl2 = {if2.alusrc_EX, if2.regwrite_EX, if2.regsel_EX, if2.aluop_EX, if2.gpio_we_EX};
   assign ctl3 = {if3.alusrc_EX, if3.regwrite_EX, if3.regsel_EX, if3.aluop_EX, if3.gpio_we_EX};
   assign ctlw = {ifw.alusrc_EX, ifw.regwrite_EX, ifw.regsel_EX, ifw.aluop_EX, ifw.gpio_we_EX};

   typedef struct {
      logic [31:0] instr;
      logic [9:0]  ctl;
      logic        ill;
      string       nm;
   } vec_t;
   vec_t vecs[$];

   function automatic logic [9:0] mk(input logic a, input logic rw, input logic [2:0] sel,
                                     input logic [3:0] op, input logic g);
      return {a, rw, sel, op, g};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; valid = 1'b0; br = 1'b0; clr = 1'b0; instr = '0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   initial begin
      vecs.push_back('{32'h003100B3, mk(0,1,3'd2,4'h3,0), 1'b0, "add"});
      vecs.push_back('{32'h403100B3, mk(0,1,3'd2,4'h4,0), 1'b0, "sub"});
      vecs.push_back('{32'h003170B3, mk(0,1,3'd2,4'h0,0), 1'b0, "and"});
      vecs.push_back('{32'h003160B3, mk(0,1,3'd2,4'h1,0), 1'b0, "or"});
      vecs.push_back('{32'h003140B3, mk(0,1,3'd2,4'h2,0), 1'b0, "xor"});
      vecs.push_back('{32'h003110B3, mk(0,1,3'd2,4'h8,0), 1'b0, "sll"});
      vecs.push_back('{32'h003150B3, mk(0,1,3'd2,4'h9,0), 1'b0, "srl"});
      vecs.push_back('{32'h403150B3, mk(0,1,3'd2,4'hA,0), 1'b0, "sra"});
      vecs.push_back('{32'h003120B3, mk(0,1,3'd2,4'hC,0), 1'b0, "slt"});
      vecs.push_back('{32'h003130B3, mk(0,1,3'd2,4'hD,0), 1'b0, "sltu"});
      vecs.push_back('{32'h023100B3, mk(0,1,3'd2,4'h5,0), 1'b0, "mul"});
      vecs.push_back('{32'h023110B3, mk(0,1,3'd2,4'h6,0), 1'b0, "mulh"});
      vecs.push_back('{32'h023130B3, mk(0,1,3'd2,4'h7,0), 1'b0, "mulhu"});
      vecs.push_back('{32'h023120B3, 10'd0,               1'b1, "mulhsu_ill"});
      vecs.push_back('{32'h403110B3, 10'd0,               1'b1, "r_f7_ill"});
      vecs.push_back('{32'h4020D093, mk(1,1,3'd2,4'hA,0), 1'b0, "srai"});
      vecs.push_back('{32'h0020D093, mk(1,1,3'd2,4'h9,0), 1'b0, "srli"});
      vecs.push_back('{32'h00510093, mk(1,1,3'd2,4'h3,0), 1'b0, "addi"});
      vecs.push_back('{32'h00517093, mk(1,1,3'd2,4'h0,0), 1'b0, "andi"});
      vecs.push_back('{32'h123450B7, mk(0,1,3'd1,4'h0,0), 1'b0, "lui"});
      vecs.push_back('{32'h00011073, mk(0,1,3'd0,4'h0,1), 1'b0, "csrrw"});
      vecs.push_back('{32'h00012073, 10'd0,               1'b1, "csr_ill"});
      vecs.push_back('{32'h00000063, mk(0,0,3'd0,4'h4,0), 1'b0, "beq"});
      vecs.push_back('{32'h00005063, mk(0,0,3'd0,4'hC,0), 1'b0, "bge"});
      vecs.push_back('{32'h00006063, mk(0,0,3'd0,4'hD,0), 1'b0, "bltu"});
      vecs.push_back('{32'h00002063, 10'd0,               1'b1, "br_ill"});
      vecs.push_back('{32'hFFFFFFFF, 10'd0,               1'b1, "ones_ill"});
      vecs.push_back('{32'h00000000, 10'd0,               1'b1, "zero_ill"});

      // reset state
      do_reset();
      chk("rst_ctl2", 32'(ctl2), 32'd0);
      chk("rst_ctl3", 32'(ctl3), 32'd0);
      chk("rst_misc2", {28'd0, if2.pcsrc_EX, if2.stall_FETCH, if2.illegal_sticky}, 32'd0);
      chk("rst_misc3", {28'd0, if3.pcsrc_EX, if3.stall_FETCH, if3.illegal_sticky}, 32'd0);
      chk("rst_cnt2", if2.retired_cnt, 32'd0);
      chk("rst_cntw", 32'(ifw.retired_cnt), 32'd0);

      // add with retire latency
      instr = 32'h003100B3; valid = 1'b1; tick();
      chk("add_ctl", 32'(ctl2), 32'(mk(0,1,3'd2,4'h3,0)));
      chk("add_cnt0", if2.retired_cnt, 32'd0);
      valid = 1'b0; tick();
      chk("add_cnt1", if2.retired_cnt, 32'd1);
      chk("idle_stall", 32'(if2.stall_FETCH), 32'd0);
      chk("idle_bubble", 32'(ctl2), 32'd0);

      // decode table
      do_reset();
      for (int unsigned i = 0; i < vecs.size(); i++) begin
         instr = vecs[i].instr; valid = 1'b1; clr = 1'b0; tick();
         chk({vecs[i].nm, "_ctl"}, 32'(ctl2), 32'(vecs[i].ctl));
         chk({vecs[i].nm, "_ill"}, 32'(if2.illegal_sticky), 32'(vecs[i].ill));
         chk({vecs[i].nm, "_pc_st"}, {30'd0, if2.pcsrc_EX} + {31'd0, if2.stall_FETCH}, 32'd0);
         valid = 1'b0; clr = 1'b1; tick();
         chk({vecs[i].nm, "_clr"}, 32'(if2.illegal_sticky), 32'd0);
         clr = 1'b0;
      end

      // jal: FLUSH_CYCLES=2 on u_dut2, FLUSH_CYCLES=1 on u_dutw
      do_reset();
      instr = 32'h008000EF; valid = 1'b1; tick();
      chk("jal_pcsrc", 32'(if2.pcsrc_EX), 32'd1);
      chk("jal_stall0", 32'(if2.stall_FETCH), 32'd1);
      chk("jal_ctl", 32'(ctl2), 32'(mk(0,1,3'd3,4'h0,0)));
      chk("jal_w_stall0", 32'(ifw.stall_FETCH), 32'd1);
      instr = 32'h003100B3; tick();
      chk("jal_stall1", 32'(if2.stall_FETCH), 32'd1);
      chk("jal_bub1", 32'(ctl2), 32'd0);
      chk("jal_pc1", 32'(if2.pcsrc_EX), 32'd0);
      chk("jal_cnt1", if2.retired_cnt, 32'd1);
      chk("jal_w_stall1", 32'(ifw.stall_FETCH), 32'd0);
      tick();
      chk("jal_stall2", 32'(if2.stall_FETCH), 32'd0);
      chk("jal_bub2", 32'(ctl2), 32'd0);
      chk("jal_cnt2", if2.retired_cnt, 32'd1);
      tick();
      chk("jal_resume", 32'(ctl2), 32'(mk(0,1,3'd2,4'h3,0)));
      chk("jal_cnt3", if2.retired_cnt, 32'd1);

      // beq not taken / taken
      do_reset();
      instr = 32'h00000063; valid = 1'b1; tick();
      chk("beq_nt_pc", 32'(if2.pcsrc_EX), 32'd0);
      chk("beq_nt_stall", 32'(if2.stall_FETCH), 32'd0);
      br = 1'b1; #1;
      chk("beq_t_pc", 32'(if2.pcsrc_EX), 32'd2);
      chk("beq_t_stall", 32'(if2.stall_FETCH), 32'd1);
      instr = 32'h003100B3; tick();
      br = 1'b0;
      chk("beq_bubble", 32'(ctl2), 32'd0);
      chk("beq_flush_stall", 32'(if2.stall_FETCH), 32'd1);

      // illegal sticky, set beats clear, wrong-path illegal squashed
      do_reset();
      instr = 32'hFFFFFFFF; valid = 1'b1; tick();
      chk("ill_ctl", 32'(ctl2), 32'd0);
      chk("ill_set", 32'(if2.illegal_sticky), 32'd1);
      clr = 1'b1; tick();
      chk("ill_set_wins", 32'(if2.illegal_sticky), 32'd1);
      valid = 1'b0; tick();
      chk("ill_cleared", 32'(if2.illegal_sticky), 32'd0);
      clr = 1'b0;
      instr = 32'h008000EF; valid = 1'b1; tick();
      instr = 32'hFFFFFFFF; tick();
      chk("ill_squash0", 32'(if2.illegal_sticky), 32'd0);
      tick();
      chk("ill_squash1", 32'(if2.illegal_sticky), 32'd0);
      valid = 1'b0; tick();

      // 2-bit retired counter wraps
      do_reset();
      instr = 32'h003100B3; valid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("wrap_cnt", 32'(ifw.retired_cnt), 32'((k - 1) % 4));
      end

      // reset taken while u_dut3 sits in FLUSH
      do_reset();
      instr = 32'h008000EF; valid = 1'b1; tick();
      instr = 32'h003100B3; tick();
      chk("f3_in_flush", 32'(if3.stall_FETCH), 32'd1);
      rst_n = 1'b0; tick();
      chk("f3_rst_ctl", 32'(ctl3), 32'd0);
      chk("f3_rst_misc", {28'd0, if3.pcsrc_EX, if3.stall_FETCH, if3.illegal_sticky}, 32'd0);
      chk("f3_rst_cnt", if3.retired_cnt, 32'd0);
      rst_n = 1'b1; tick();
      chk("f3_run_load", 32'(ctl3), 32'(mk(0,1,3'd2,4'h3,0)));
      valid = 1'b0; tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 The module SHALL have parameter FLUSH_CYCLES, default 1, range 1..3, setting the number of bubbles inserted into EX after a redirect.
REQ-002 The module SHALL have parameter EN_MUL, default 1, where 1 decodes mul/mulh/mulhu and 0 treats them as illegal.
REQ-003 The module SHALL have parameter CNT_W, default 32, setting the width of retired_cnt.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The module SHALL have port instr_F, input, 32 bits: the instruction in the FETCH stage.
REQ-007 The module SHALL have port valid_F, input, 1 bit: instr_F is valid.
REQ-008 The module SHALL have port br_taken_EX, input, 1 bit: the ALU compare result for the branch currently in EX.
REQ-009 The module SHALL have port illegal_clr, input, 1 bit: clears illegal_sticky.
REQ-010 The module SHALL have output alusrc_EX, 1 bit, registered: select imm (1) or readdata2 (0) for the ALU.
REQ-011 The module SHALL have output regwrite_EX, 1 bit, registered: regfile write enable.
REQ-012 The module SHALL have output regsel_EX, 3 bits, registered: writeback source, 0 = GPIO/CSR, 1 = imm_U, 2 = ALU, 3 = PC+4.
REQ-013 The module SHALL have output aluop_EX, 4 bits, registered: ALU operation.
REQ-014 The module SHALL have output gpio_we_EX, 1 bit, registered: GPIO output register write enable.
REQ-015 The module SHALL have output pcsrc_EX, 2 bits, combinational from EX state: 0 = PC+4, 1 = jal target, 2 = branch target.
REQ-016 The module SHALL have output stall_FETCH, 1 bit, combinational: hold/squash the FETCH stage.
REQ-017 The module SHALL have output illegal_sticky, 1 bit, registered: an undecodable instruction was seen.
REQ-018 The module SHALL have output retired_cnt, CNT_W bits, registered: count of non-bubble instructions that occupied EX.

Function
REQ-019 Decoding of opcode 0110011 (R-type) SHALL set regwrite=1 and regsel=2, with aluop:
- funct7 0000000: add 0011, and 0000, or 0001, xor 0010, sll 1000, srl 1001, slt 1100, sltu 1101.
- funct7 0100000: sub 0100, sra 1010.
- funct7 0000001 (EN_MUL=1 only): mul 0101, mulh 0110, mulhu 0111.
REQ-020 Decoding of opcode 0010011 (I-type) SHALL set regwrite=1, alusrc=1 and regsel=2, with addi/andi/ori/xori/slli as in REQ-019; funct3 101 SHALL decode to srai (1010) when instr_F[30]=1 and to srli (1001) otherwise.
REQ-021 Decoding of opcode 0110111 (lui) SHALL set regwrite=1 and regsel=1.
REQ-022 Decoding of opcode 1101111 (jal) SHALL set regwrite=1 and regsel=3, and mark the EX instruction as a jump.
REQ-023 Decoding of opcode 1110011 with funct3 001 (csrrw) SHALL set gpio_we=1, regwrite=1 and regsel=0.
REQ-024 Decoding of opcode 1100011 (branch) SHALL set regwrite=0 and mark the EX instruction as a branch, with aluop 0100 for beq/bne, 1100 for blt/bge, 1101 for bltu/bgeu; funct3 010 and 011 SHALL be illegal.
REQ-025 Any other encoding SHALL produce all-zero controls and flag the instruction as illegal.
REQ-026 EX registers SHALL load the decoded fields 1 cycle after FETCH when the state is RUN, valid_F=1 and there is no redirect; in every other case they SHALL load a bubble (all controls 0, not valid).
REQ-027 A redirect SHALL occur when the EX instruction is a jump, or is a branch with br_taken_EX=1.
REQ-028 pcsrc_EX SHALL be 1 for a jump in EX, 2 for a taken branch in EX, and 0 otherwise.
REQ-029 The FSM SHALL have states RUN and FLUSH:
- In RUN, a redirect SHALL insert a bubble at the next edge.
- If FLUSH_CYCLES>1, a redirect SHALL also move the FSM to FLUSH with cnt=FLUSH_CYCLES-1.
- In FLUSH, each cycle SHALL insert a bubble and decrement cnt; when cnt=1 the FSM SHALL return to RUN at that edge.
REQ-030 stall_FETCH SHALL be 1 during the redirect cycle and every FLUSH cycle, giving exactly FLUSH_CYCLES cycles high per redirect.
REQ-031 illegal_sticky SHALL set when an illegal instruction is loaded under REQ-026; a wrong-path illegal instruction squashed by a redirect SHALL NOT set it.
REQ-032 illegal_clr SHALL clear illegal_sticky; if set and clear occur in the same cycle, set SHALL win.
REQ-033 retired_cnt SHALL increment by 1 for each cycle EX holds a valid non-bubble instruction, and SHALL wrap modulo 2^CNT_W.
REQ-034 An unused stage SHALL create no back-pressure: with valid_F=0 in RUN, bubbles SHALL flow and stall_FETCH SHALL be 0.

Reset
REQ-035 rst_n=0 at a clock edge SHALL force all registered outputs to 0, the state to RUN, cnt to 0, illegal_sticky to 0 and retired_cnt to 0.
REQ-036 Reset SHALL take priority over all other inputs, including while in FLUSH; stall_FETCH SHALL be 0 in the cycle after reset.

Verification
REQ-037 A bench SHALL drive 0x003100B3 (add x1,x2,x3) with valid_F=1 and check: next cycle regwrite_EX=1, regsel_EX=2, aluop_EX=0011, alusrc_EX=0; retired_cnt=1 one cycle later.
REQ-038 A bench SHALL drive 0x4020D093 and check aluop_EX=1010, then drive 0x0020D093 and check aluop_EX=1001, with alusrc_EX=1 for both.
REQ-039 A bench SHALL drive 0x008000EF (jal) with FLUSH_CYCLES=2 and check: pcsrc_EX=1 and stall_FETCH=1 for 2 cycles, 2 bubbles in EX, regsel_EX=3, and retired_cnt advancing by 1 only.
REQ-040 A bench SHALL drive 0x00000063 (beq): with br_taken_EX=0, pcsrc_EX=0 and stall_FETCH=0; with br_taken_EX=1, pcsrc_EX=2, stall_FETCH=1 and a bubble follows.
REQ-041 A bench SHALL drive 0xFFFFFFFF and check all controls 0 and illegal_sticky=1; then assert illegal_clr together with a second illegal instruction and check illegal_sticky stays 1.
REQ-042 A bench SHALL assert rst_n=0 in a FLUSH cycle (FLUSH_CYCLES=3) and check: next cycle all outputs 0, stall_FETCH=0, state RUN.
